// File: rtl/axi4_block_master_pkg.sv
// ----------------------------------------------------------------------------
// axi4_block_master_pkg
// Shared types and constants for the AXI4 block burst master and its beat
// counter.
//   t_axi_state     : master FSM states
//   AXI_BURST_INCR  : AXI4 INCR burst encoding
//   AXI_RESP_OKAY   : AXI4 OKAY response encoding
//   axiSizeCode     : AxSIZE code for a given data bus width
//   blockOffsetBits : number of byte-offset bits inside one cache block
// ----------------------------------------------------------------------------
package axi4_block_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR_REQ,
        R_DATA,
        AW_REQ,
        W_DATA,
        B_WAIT
    } t_axi_state;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AxSIZE is log2 of the bytes moved per beat.
    function automatic int axiSizeCode(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

    // Low address bits that select a byte inside one cache block.
    function automatic int blockOffsetBits(input int blockWords, input int dataWidth);
        return $clog2(blockWords * dataWidth / 8);
    endfunction

endpackage

// File: rtl/axi4_block_master_beat_counter.sv
// ----------------------------------------------------------------------------
// axi_beat_counter
// Beat index counter shared by the refill (R) and writeback (W) bursts.
//   clk      : clock
//   arstn    : asynchronous reset, active-low
//   i_clear  : return the count to zero (wins over i_enable)
//   i_enable : one beat accepted this cycle
//   o_count  : current beat index
//   o_last   : count has reached the final beat of the burst
// ----------------------------------------------------------------------------
module axi_beat_counter #(
    parameter int WIDTH = 4,
    parameter int LAST  = 15
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign o_last  = (count_q == WIDTH'(LAST));
    assign o_count = count_q;

    // The count saturates on the final beat so a slave that sends extra R
    // beats without RLAST can never wrap the index mid-burst; only a clear
    // at completion returns it to zero.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && !o_last) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi4_block_master.sv
// ----------------------------------------------------------------------------
// axi4_block_master
// Memory-side burst engine for the data cache. A held start_write issues one
// AW + W INCR burst of one cache block and waits for B; a held start_read
// issues one AR INCR burst and streams R beats into the data array. Write
// wins when both requests are high. Completion pulses (o_r_last, o_b_resp)
// are combinational so the cache FSM can leave its state on the next edge,
// at which point this master is already back in IDLE.
//
// Ports:
//   clk, arstn                : clock, asynchronous active-low reset
//   i_start_read/i_start_write: held request levels from the cache FSM
//   i_addr                    : block address (offset bits ignored)
//   i_wdata / o_word_idx      : writeback word selected by the beat index
//   o_rdata, o_rdata_valid    : refill word and its strobe
//   o_r_last, o_b_resp        : completion pulses
//   o_ar*/i_arready, i_r*/o_rready, o_aw*/i_awready, o_w*/i_wready,
//   i_b*/o_bready             : AXI4 master channels
//
// Optional feature (macro AXI_RESP_CHECK_EN): adds o_bus_error, a sticky flag
// raised by any non-OKAY RRESP or BRESP on an accepted beat, cleared by reset.
// ----------------------------------------------------------------------------
module axi4_block_master
    import axi4_block_master_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 16
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        i_start_read,
    input  logic                        i_start_write,
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic                        o_rdata_valid,
    output logic                        o_r_last,
    output logic                        o_b_resp,
`ifdef AXI_RESP_CHECK_EN
    output logic                        o_bus_error,
`endif
    // AR channel
    output logic [ADDR_WIDTH-1:0]       o_araddr,
    output logic [7:0]                  o_arlen,
    output logic [2:0]                  o_arsize,
    output logic [1:0]                  o_arburst,
    output logic                        o_arvalid,
    input  logic                        i_arready,
    // R channel
    input  logic [DATA_WIDTH-1:0]       i_rdata,
    input  logic [1:0]                  i_rresp,
    input  logic                        i_rlast,
    input  logic                        i_rvalid,
    output logic                        o_rready,
    // AW channel
    output logic [ADDR_WIDTH-1:0]       o_awaddr,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    // W channel
    output logic [DATA_WIDTH-1:0]       o_wdata,
    output logic [DATA_WIDTH/8-1:0]     o_wstrb,
    output logic                        o_wlast,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    // B channel
    input  logic [1:0]                  i_bresp,
    input  logic                        i_bvalid,
    output logic                        o_bready
);

    localparam int IDX_W    = $clog2(BLOCK_WORDS);
    localparam int OFF_BITS = blockOffsetBits(BLOCK_WORDS, DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFF_BITS;

    t_axi_state            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;

    logic [IDX_W-1:0]      beatIdx;
    logic                  beatLast;
    logic                  rBeat;
    logic                  rDone;
    logic                  wBeat;
    logic                  wDone;
    logic                  bDone;
    logic                  cntClear;
    logic                  cntEnable;

    // Handshakes. The ready/valid flags are only ever high in their own
    // state, so they double as state decodes.
    assign rBeat = rready_q & i_rvalid;
    assign rDone = rBeat & i_rlast;
    assign wBeat = wvalid_q & i_wready;
    assign wDone = wBeat & beatLast;
    assign bDone = bready_q & i_bvalid;

    // The counter sits at zero outside data phases and clears on completion.
    // RLAST, not the count, ends a refill.
    assign cntClear  = ~(rready_q | wvalid_q) | rDone | wDone;
    assign cntEnable = rBeat | wBeat;

    axi_beat_counter #(
        .WIDTH (IDX_W),
        .LAST  (BLOCK_WORDS - 1)
    ) u_beat_counter (
        .clk      (clk),
        .arstn    (arstn),
        .i_clear  (cntClear),
        .i_enable (cntEnable),
        .o_count  (beatIdx),
        .o_last   (beatLast)
    );

    // Master FSM. The address is captured once on leaving IDLE and held, so
    // the cache may change i_addr or drop its request mid-transaction.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start_write) begin
                        state_q   <= AW_REQ;
                        awvalid_q <= 1'b1;
                        addr_q    <= i_addr & ADDR_MASK;
                    end else if (i_start_read) begin
                        state_q   <= AR_REQ;
                        arvalid_q <= 1'b1;
                        addr_q    <= i_addr & ADDR_MASK;
                    end
                end
                AR_REQ: begin
                    if (i_arready) begin
                        state_q   <= R_DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rDone) begin
                        state_q  <= IDLE;
                        rready_q <= 1'b0;
                    end
                end
                AW_REQ: begin
                    if (i_awready) begin
                        state_q   <= W_DATA;
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wDone) begin
                        state_q  <= B_WAIT;
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                    end
                end
                B_WAIT: begin
                    if (i_bvalid) begin
                        state_q  <= IDLE;
                        bready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef AXI_RESP_CHECK_EN
    logic busError_q;

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            busError_q <= 1'b0;
        end else if ((rBeat && (i_rresp != AXI_RESP_OKAY)) ||
                     (bDone && (i_bresp != AXI_RESP_OKAY))) begin
            busError_q <= 1'b1;
        end
    end

    assign o_bus_error = busError_q;
`else
    logic unusedResp;
    assign unusedResp = ^{i_rresp, i_bresp};
`endif

    // Cache-side outputs
    assign o_word_idx    = beatIdx;
    assign o_rdata       = i_rdata;
    assign o_rdata_valid = rBeat;
    assign o_r_last      = rDone;
    assign o_b_resp      = bDone;

    // AR channel
    assign o_araddr  = addr_q;
    assign o_arlen   = 8'(BLOCK_WORDS - 1);
    assign o_arsize  = 3'(axiSizeCode(DATA_WIDTH));
    assign o_arburst = AXI_BURST_INCR;
    assign o_arvalid = arvalid_q;
    assign o_rready  = rready_q;

    // AW / W / B channels
    assign o_awaddr  = addr_q;
    assign o_awlen   = 8'(BLOCK_WORDS - 1);
    assign o_awsize  = 3'(axiSizeCode(DATA_WIDTH));
    assign o_awburst = AXI_BURST_INCR;
    assign o_awvalid = awvalid_q;
    assign o_wdata   = i_wdata;
    assign o_wstrb   = '1;
    assign o_wlast   = wvalid_q & beatLast;
    assign o_wvalid  = wvalid_q;
    assign o_bready  = bready_q;

endmodule
